// File: rtl/plic_gw_pkg.sv
// Shared definitions for the PLIC interrupt gateway array.
//   gw_mode_e              : per-channel trigger mode (level / edge)
//   GW_NUM_SRC_DEFAULT     : default channel count
//   GW_EDGE_CNT_W_DEFAULT  : default width of the pending-edge counter
package plic_gw_pkg;

    typedef enum logic {
        GW_LEVEL = 1'b0,
        GW_EDGE  = 1'b1
    } gw_mode_e;

    localparam int unsigned GW_NUM_SRC_DEFAULT    = 8;
    localparam int unsigned GW_EDGE_CNT_W_DEFAULT = 2;

endpackage

// File: rtl/plic_gateway_chan.sv
// One interrupt gateway channel.
//   clock, reset         : clock and synchronous active-high reset
//   interrupt            : raw interrupt line (already synchronised)
//   mode                 : 0 = level, 1 = edge triggered
//   plic_ready           : PLIC accepts a request this cycle
//   plic_complete        : single-cycle completion pulse
//   plic_valid           : request to the PLIC
//   overflow_clear/overflow : sticky pending-counter overflow status, present
//                          only when PLIC_GW_OVERFLOW_STATUS_EN is defined
module plic_gateway_chan
    import plic_gw_pkg::*;
#(
    parameter int unsigned EDGE_CNT_W = GW_EDGE_CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic interrupt,
    input  logic mode,
    input  logic plic_ready,
    input  logic plic_complete,
    output logic plic_valid
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
    ,
    input  logic overflow_clear,
    output logic overflow
`endif
);

    localparam logic [EDGE_CNT_W-1:0] PEND_MAX = '1;

    gw_mode_e               mode_e;
    gw_mode_e               mode_q_reg;
    logic                   in_flight_reg, in_flight_next;
    logic                   prev_reg;
    logic [EDGE_CNT_W-1:0]  pend_reg, pend_next;
    logic                   mode_change;
    logic                   rise;
    logic                   accept;

    assign mode_e = gw_mode_e'(mode);

    always_comb begin
        mode_change = (mode_e != mode_q_reg);
        rise        = interrupt & ~prev_reg;

        if (mode_e == GW_EDGE) begin
            plic_valid = (pend_reg != '0) & ~in_flight_reg & ~mode_change;
        end else begin
            plic_valid = interrupt & ~in_flight_reg & ~mode_change;
        end
        accept = plic_valid & plic_ready;

        pend_next = pend_reg;
        if (mode_e == GW_LEVEL) begin
            pend_next = '0;
        end else if (mode_change) begin
            // Old count is discarded; an edge seen in the switching cycle
            // is counted afresh so a line high right after reset still
            // produces a request.
            pend_next    = '0;
            pend_next[0] = rise;
        end else if (rise & ~accept) begin
            if (pend_reg != PEND_MAX) begin
                pend_next = pend_reg + 1'b1;
            end
        end else if (accept & ~rise) begin
            pend_next = pend_reg - 1'b1;
        end

        // Completion wins over a same-cycle accept.
        in_flight_next = ~plic_complete & (accept | in_flight_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight_reg <= 1'b0;
            prev_reg      <= 1'b0;
            pend_reg      <= '0;
            mode_q_reg    <= GW_LEVEL;
        end else begin
            in_flight_reg <= in_flight_next;
            prev_reg      <= interrupt;
            pend_reg      <= pend_next;
            mode_q_reg    <= mode_e;
        end
    end

`ifdef PLIC_GW_OVERFLOW_STATUS_EN
    logic overflow_reg, overflow_next;

    always_comb begin
        // Set has priority over a coincident clear.
        overflow_next = (overflow_reg & ~overflow_clear)
                      | ((mode_e == GW_EDGE) & ~mode_change & rise & ~accept
                         & (pend_reg == PEND_MAX));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: rtl/plic_gateway_array.sv
// Array of independent PLIC interrupt gateways, one per source.
//   clock, reset      : clock and synchronous active-high reset
//   io_interrupt      : raw interrupt lines
//   io_mode           : per-channel trigger mode (0 level, 1 edge)
//   io_plic_ready     : PLIC accepts the request on a channel
//   io_plic_complete  : per-channel completion pulse
//   io_plic_valid     : per-channel request to the PLIC
//   io_overflow_clear / io_overflow : sticky overflow status, only when
//                       PLIC_GW_OVERFLOW_STATUS_EN is defined
module plic_gateway_array
    import plic_gw_pkg::*;
#(
    parameter int unsigned NUM_SRC    = GW_NUM_SRC_DEFAULT,
    parameter int unsigned EDGE_CNT_W = GW_EDGE_CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] io_interrupt,
    input  logic [NUM_SRC-1:0] io_mode,
    input  logic [NUM_SRC-1:0] io_plic_ready,
    input  logic [NUM_SRC-1:0] io_plic_complete,
    output logic [NUM_SRC-1:0] io_plic_valid
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
    ,
    input  logic [NUM_SRC-1:0] io_overflow_clear,
    output logic [NUM_SRC-1:0] io_overflow
`endif
);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_chan
        plic_gateway_chan #(
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_chan (
            .clock          (clock),
            .reset          (reset),
            .interrupt      (io_interrupt[gi]),
            .mode           (io_mode[gi]),
            .plic_ready     (io_plic_ready[gi]),
            .plic_complete  (io_plic_complete[gi]),
            .plic_valid     (io_plic_valid[gi])
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
            ,
            .overflow_clear (io_overflow_clear[gi]),
            .overflow       (io_overflow[gi])
`endif
        );
    end

endmodule

// File: tb/tb_plic_gateway_array.sv
module tb_plic_gateway_array;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int MAXP = (1 << CW) - 1;

    logic         clock;
    logic         reset;
    logic [N-1:0] intr, mode, ready, cmpl, valid;
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
    logic [N-1:0] ovf_clr, ovf;
`endif

    plic_gateway_array #(.NUM_SRC(N), .EDGE_CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_interrupt     (intr),
        .io_mode          (mode),
        .io_plic_ready    (ready),
        .io_plic_complete (cmpl),
        .io_plic_valid    (valid)
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
        ,
        .io_overflow_clear(ovf_clr),
        .io_overflow      (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Abstract model: pending count as an integer, busy flag, last line.
    int m_pend [N];
    bit m_busy [N];
    bit m_prev [N];
    bit m_modeq[N];
    bit m_ovf  [N];

    // Literal expectations posted by the stimulus, consumed by the checker.
    // kind 0: DUT valid bit, 1: model pend count, 2: DUT overflow bit,
    // 3: accept count seen by the stimulus.
    typedef struct {
        string name;
        int    kind;
        int    ch;
        int    exp;
    } lit_t;
    lit_t lits[$];
    int   lit_rd = 0;
    int   acc_cnt = 0;
    bit   done = 1'b0;

    int   checks = 0;
    int   errors = 0;
    logic [N-1:0] exp_v;
    int   rise_i, acc_i, chg_i, act_i;

    function automatic bit model_valid(int i);
        if (mode[i] != m_modeq[i]) return 1'b0;
        if (m_busy[i]) return 1'b0;
        if (mode[i]) return (m_pend[i] > 0);
        return intr[i];
    endfunction

    task automatic post(string n, int kind, int ch, int e);
        lit_t t;
        t.name = n; t.kind = kind; t.ch = ch; t.exp = e;
        lits.push_back(t);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        initial_watchdog();
    end

    task automatic initial_watchdog();
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    endtask

    // Compare process: checks every cycle, then advances the model.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) exp_v[i] = model_valid(i);
        checks++;
        if (valid !== exp_v) begin
            errors++;
            $display("FAIL valid_vs_model t=%0t: actual %b required %b", $time, valid, exp_v);
        end
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ovf[i] !== m_ovf[i]) begin
                errors++;
                $display("FAIL overflow_vs_model ch%0d t=%0t: actual %b required %b", i, $time, ovf[i], m_ovf[i]);
            end
        end
`endif
        while (lit_rd < lits.size()) begin
            case (lits[lit_rd].kind)
                0: act_i = int'(valid[lits[lit_rd].ch]);
                1: act_i = m_pend[lits[lit_rd].ch];
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
                2: act_i = int'(ovf[lits[lit_rd].ch]);
`endif
                default: act_i = acc_cnt;
            endcase
            checks++;
            if (act_i != lits[lit_rd].exp) begin
                errors++;
                $display("FAIL %s: actual %0d required %0d", lits[lit_rd].name, act_i, lits[lit_rd].exp);
            end
            lit_rd++;
        end

        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_pend[i] = 0; m_busy[i] = 0; m_prev[i] = 0; m_modeq[i] = 0; m_ovf[i] = 0;
            end else begin
                rise_i = (intr[i] && !m_prev[i]) ? 1 : 0;
                acc_i  = (exp_v[i] && ready[i]) ? 1 : 0;
                chg_i  = (mode[i] != m_modeq[i]) ? 1 : 0;
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
                if (mode[i] && chg_i == 0 && rise_i == 1 && acc_i == 0 && m_pend[i] == MAXP)
                    m_ovf[i] = 1'b1;
                else if (ovf_clr[i])
                    m_ovf[i] = 1'b0;
`endif
                if (chg_i == 1) m_pend[i] = mode[i] ? rise_i : 0;
                else if (!mode[i]) m_pend[i] = 0;
                else begin
                    m_pend[i] = m_pend[i] + rise_i - acc_i;
                    if (m_pend[i] > MAXP) m_pend[i] = MAXP;
                end
                m_busy[i]  = !cmpl[i] && (acc_i == 1 || m_busy[i]);
                m_prev[i]  = intr[i];
                m_modeq[i] = mode[i];
            end
        end

        if (done) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        reset = 1'b1; intr = '0; mode = 4'b1110; ready = '0; cmpl = '0;
`ifdef PLIC_GW_OVERFLOW_STATUS_EN
        ovf_clr = '0;
`endif
        tick(); tick();
        post("reset_valid_ch0", 0, 0, 0);
        post("reset_valid_ch1", 0, 1, 0);
        tick(); reset = 1'b0;
        post("post_reset_valid_ch1", 0, 1, 0);
        tick();

        // Level channel 0
        intr[0] = 1'b1;                 post("lvl_raise", 0, 0, 1);
        tick(); ready[0] = 1'b1;        post("lvl_accept_cycle", 0, 0, 1);
        tick(); ready[0] = 1'b0;        post("lvl_inflight", 0, 0, 0);
        tick(); tick();
        tick(); cmpl[0] = 1'b1;         post("lvl_complete_cycle", 0, 0, 0);
        tick(); cmpl[0] = 1'b0;         post("lvl_rerequest", 0, 0, 1);
        tick(); intr[0] = 1'b0;         post("lvl_line_low", 0, 0, 0);

        // Edge burst on channel 1: four edges saturate at 3
        repeat (4) begin tick(); intr[1] = 1'b1; tick(); intr[1] = 1'b0; end
        post("burst_pend_model", 1, 1, 3);
        post("burst_valid", 0, 1, 1);
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); ready[1] = 1'b1; cmpl[1] = 1'b0;
            #1;
            if (valid[1]) acc_cnt++;
            tick(); ready[1] = 1'b0; cmpl[1] = 1'b1;
        end
        tick(); cmpl[1] = 1'b0;
        post("burst_accepts", 3, 1, 3);
        post("burst_drained", 0, 1, 0);

        // Channel 2: edge+accept, then accept+complete
        tick(); intr[2] = 1'b1;
        tick(); intr[2] = 1'b0;
        tick(); intr[2] = 1'b1;
        tick(); intr[2] = 1'b0;                         post("sim_pend_valid", 0, 2, 1);
        tick(); intr[2] = 1'b1; ready[2] = 1'b1;        post("sim_edge_accept", 0, 2, 1);
        tick(); intr[2] = 1'b0; ready[2] = 1'b0;        post("sim_inflight", 0, 2, 0);
                                                        post("sim_pend_unchanged", 1, 2, 2);
        tick(); cmpl[2] = 1'b1;                         post("sim_complete_cycle", 0, 2, 0);
        tick(); cmpl[2] = 1'b0;                         post("sim_after_complete", 0, 2, 1);
        tick(); ready[2] = 1'b1; cmpl[2] = 1'b1;        post("sim_accept_complete", 0, 2, 1);
        tick(); ready[2] = 1'b0; cmpl[2] = 1'b0;        post("sim_complete_wins", 0, 2, 1);
                                                        post("sim_pend_after", 1, 2, 1);

        // Channel 3: edge -> level switch with two pending edges
        tick(); intr[3] = 1'b1;
        tick(); intr[3] = 1'b0;
        tick(); intr[3] = 1'b1;
        tick(); intr[3] = 1'b0;                         post("mode_pend_before", 1, 3, 2);
        tick(); mode[3] = 1'b0; intr[3] = 1'b1;         post("mode_switch_cycle", 0, 3, 0);
        tick();                                         post("mode_level_follow", 0, 3, 1);
                                                        post("mode_pend_cleared", 1, 3, 0);
        tick(); intr[3] = 1'b0;

        // Reset mid-flight on channel 1
        repeat (4) begin tick(); intr[1] = 1'b1; tick(); intr[1] = 1'b0; end
        tick(); ready[1] = 1'b1;
        tick(); ready[1] = 1'b0; intr[1] = 1'b1;
        tick(); intr[1] = 1'b0;                         post("rst_pend_before", 1, 1, 3);
                                                        post("rst_inflight_before", 0, 1, 0);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;                           post("rst_after_c1", 0, 1, 0);
        tick();                                         post("rst_after_c2", 0, 1, 0);
                                                        post("rst_pend_zero", 1, 1, 0);
        intr[1] = 1'b1;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;                           post("held_c1", 0, 1, 0);
        tick();                                         post("held_c2", 0, 1, 1);
        tick(); intr[1] = 1'b0;

`ifdef PLIC_GW_OVERFLOW_STATUS_EN
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        repeat (3) begin tick(); intr[1] = 1'b1; tick(); intr[1] = 1'b0; end
        tick(); intr[1] = 1'b1;                         post("ovf_not_yet", 2, 1, 0);
        tick(); intr[1] = 1'b0;                         post("ovf_set", 2, 1, 1);
        tick(); ovf_clr[1] = 1'b1;                      post("ovf_clear_cycle", 2, 1, 1);
        tick(); ovf_clr[1] = 1'b0;                      post("ovf_cleared", 2, 1, 0);
        tick(); intr[1] = 1'b1; ovf_clr[1] = 1'b1;
        tick(); intr[1] = 1'b0; ovf_clr[1] = 1'b0;      post("ovf_set_wins", 2, 1, 1);
`endif

        tick(); tick();
        done = 1'b1;
    end

endmodule
